// File: rtl/calculator_pkg.sv
// rtl/calculator_pkg.sv - shared calculator constants and helpers
package calculator_pkg;

  localparam int DIGIT_W = 4;

  // True when NDIGITS decimal digits can hold every BITS-bit unsigned value.
  function automatic bit bcd_fits(input int bits, input int ndigits);
    logic [255:0] p;
    p = 256'd1;
    for (int i = 0; i < ndigits; i++) p = p * 256'd10;
    return p > (256'd1 << bits);
  endfunction

endpackage

// File: rtl/accum_bcd_convert.sv
// rtl/accum_bcd_convert.sv - sequential shift-and-add-3 binary to sign+BCD converter
module accum_bcd_convert
  import calculator_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int NDIGITS = 10,
  parameter int SIGNED  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BITS-1:0]            accum,
  output logic [DIGIT_W*NDIGITS-1:0] bcd,
  output logic                       sign,
  output logic [NDIGITS-1:0]         digit_en,
  output logic                       busy,
  output logic                       done
);

  localparam int BW = DIGIT_W * NDIGITS;
  localparam int CW = $clog2(BITS + 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  if (!bcd_fits(BITS, NDIGITS)) begin : g_size_check
    $fatal(1, "accum_bcd_convert: NDIGITS too small for BITS");
  end

  state_t          state;
  logic [BITS-1:0] last_value;
  logic            pending;
  logic            sign_r;
  logic [BITS-1:0] shreg;
  logic [BW-1:0]   work;
  logic [CW-1:0]   count;

  logic            neg;
  logic [BITS-1:0] mag;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   work_next;
  logic [BITS-1:0] shift_next;
  logic [NDIGITS-1:0] en_next;

  assign neg = (SIGNED != 0) && accum[BITS-1];
  assign mag = neg ? (~accum) + BITS'(1) : accum;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_adj
    assign adj[DIGIT_W*i +: DIGIT_W] = (work[DIGIT_W*i +: DIGIT_W] >= 4'd5)
                                     ? work[DIGIT_W*i +: DIGIT_W] + 4'd3
                                     : work[DIGIT_W*i +: DIGIT_W];
  end

  assign work_next  = {adj[BW-2:0], shreg[BITS-1]};
  assign shift_next = {shreg[BITS-2:0], 1'b0};

  // A digit is significant once any digit at or above it is nonzero.
  always_comb begin
    logic any;
    any     = 1'b0;
    en_next = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      any        = any | (|work_next[DIGIT_W*i +: DIGIT_W]);
      en_next[i] = any;
    end
    en_next[0] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_value <= '0;
      pending    <= 1'b1;
      sign_r     <= 1'b0;
      shreg      <= '0;
      work       <= '0;
      count      <= '0;
      bcd        <= '0;
      sign       <= 1'b0;
      digit_en   <= NDIGITS'(1);
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pending || (accum != last_value)) begin
            last_value <= accum;
            sign_r     <= neg;
            shreg      <= mag;
            work       <= '0;
            count      <= CW'(BITS);
            pending    <= 1'b0;
            busy       <= 1'b1;
            state      <= CONVERT;
          end
        end
        CONVERT: begin
          work  <= work_next;
          shreg <= shift_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd      <= work_next;
            sign     <= sign_r && (work_next != '0);
            digit_en <= en_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
